bpu_ras_param: RTL and testbench
================================

BPU_RAS_PARAM -- requirements
Module: bpu_ras_param

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; power of two, 2..64.
REQ-002 SHALL have parameter PW = $clog2(DEPTH), pointer width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port push  input  1  call retired to prediction; push push_addr.
REQ-006 SHALL have port push_addr  input  32 (virt_t)  return address (call pc + 8).
REQ-007 SHALL have port pop  input  1  return predicted; pop top.
REQ-008 SHALL have port top  output  33 (ras_t)  {valid, data} of current top of stack (TOS).
REQ-009 SHALL have port snap  output  ras_ckpt_t  {ptr[PW], count[PW+1], data[32]} of current TOS, carried down the pipe with each branch.
REQ-010 SHALL have port recover  input  1  misprediction repair request.
REQ-011 SHALL have port recover_ckpt  input  ras_ckpt_t  snapshot to restore.
REQ-012 SHALL have port ovf  output  1  registered one-cycle pulse: push overwrote the oldest entry.

Function
REQ-013 SHALL hold state: mem[DEPTH] of 32 bits, ptr (TOS index), count (0..DEPTH).
REQ-014 SHALL drive top combinationally from state: valid = (count != 0); data = mem[ptr]. Zero-latency read.
REQ-015 SHALL drive snap combinationally: {ptr, count, mem[ptr]}.
REQ-016 Push only: ptr <= ptr+1 mod DEPTH; mem[ptr+1] <= push_addr; count <= min(count+1, DEPTH).
REQ-017 Push at count == DEPTH: circular wrap; the oldest entry is overwritten, count stays DEPTH, and ovf = 1 next cycle.
REQ-018 Pop only with count > 0: ptr <= ptr-1 mod DEPTH; count <= count-1; mem unchanged.
REQ-019 Pop only with count == 0: no state change; top.valid stays 0.
REQ-020 Push and pop in the same cycle: mem[ptr] <= push_addr; ptr unchanged; count <= max(count, 1).
REQ-021 Recover SHALL have priority over push and pop, which are ignored that cycle: ptr <= recover_ckpt.ptr, count <= recover_ckpt.count, mem[recover_ckpt.ptr] <= recover_ckpt.data.
REQ-022 Recover SHALL restore the snapshot exactly; top the next cycle equals {recover_ckpt.count != 0, recover_ckpt.data}.
REQ-023 SHALL clamp a recover_ckpt.count above DEPTH to DEPTH.
REQ-024 ovf SHALL be 0 in every cycle not covered by REQ-017.
REQ-025 Entries other than those written per REQ-016/020/021 SHALL never change.

Reset
REQ-026 When resetn = 0 at a clock edge: ptr = 0, count = 0, all mem = 0, ovf = 0; push, pop and recover are ignored.
REQ-027 After reset: top = {0, 32'h0}; snap = {0, 0, 32'h0}.
REQ-028 Reset asserted mid-operation SHALL discard all entries; there is no partial state.

Structure
REQ-029 ras_t and the new ras_ckpt_t typedef, plus the `RAS_DEPTH default constant, SHALL live in the shared CPU definitions header.
REQ-030 SHALL be a single module with no sub-module; mem SHALL be flops, not RAM macros, because of the asynchronous read.
REQ-031 ras_ckpt_t SHALL be sized for the largest DEPTH in use; unused upper ptr bits SHALL be ignored.

Verification (DEPTH = 4)
REQ-032 Reset, then push 0x100, 0x200 -> top = {1, 0x200}, count = 2; pop -> top = {1, 0x100}.
REQ-033 Push 0x10, 0x20, 0x30, 0x40, 0x50 -> ovf pulses once after 0x50; then 4 pops yield 0x50, 0x40, 0x30, 0x20; a 5th pop leaves top.valid = 0.
REQ-034 count = 0, pop -> no change; push+pop of 0xA0 at count = 0 -> top = {1, 0xA0}, count = 1.
REQ-035 Capture snap at {ptr = 1, count = 2, data = 0x200}, then push 0x300 and pop twice; recover with push also asserted -> top = {1, 0x200}, ptr = 1, push ignored.
REQ-036 resetn = 0 for one cycle with count = 3 -> top = {0, 0}, snap = 0, ovf = 0 next cycle.

Source files
------------

// File: rtl/bpu_ras_param_pkg.sv
// Shared CPU definitions for the return-address stack: address, TOS view and checkpoint types.
// Checkpoint fields are sized for the largest supported stack so one pipe format serves every DEPTH.
package bpu_ras_param_pkg;

    localparam int RAS_DEPTH     = 8;
    localparam int RAS_MAX_DEPTH = 64;
    localparam int RAS_CKPT_PW   = $clog2(RAS_MAX_DEPTH);
    localparam int RAS_CKPT_CW   = RAS_CKPT_PW + 1;

    typedef logic [31:0] virt_t;

    typedef struct packed {
        logic  valid;
        virt_t data;
    } ras_t;

    typedef struct packed {
        logic [RAS_CKPT_PW-1:0] ptr;
        logic [RAS_CKPT_CW-1:0] count;
        virt_t                  data;
    } ras_ckpt_t;

endpackage

// File: rtl/bpu_ras_param.sv
// Circular return-address stack with zero-latency TOS read and checkpoint repair; recover beats push/pop.
// Updates land on the next clk edge; no backpressure, a push on a full stack overwrites the oldest entry.
module bpu_ras_param
    import bpu_ras_param_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int PW    = $clog2(DEPTH)
)(
    input  logic      clk,
    input  logic      resetn,
    input  logic      push,
    input  virt_t     push_addr,
    input  logic      pop,
    output ras_t      top,
    output ras_ckpt_t snap,
    input  logic      recover,
    input  ras_ckpt_t recover_ckpt,
    output logic      ovf
);

    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

    virt_t         r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [PW:0]   r_count;
    logic          r_ovf;

    logic [PW-1:0] w_ptr_inc;
    logic [PW-1:0] w_ptr_dec;
    logic          w_full;
    logic          w_empty;
    logic [PW-1:0] w_rc_ptr;
    logic [PW:0]   w_rc_count;
    logic          w_unused_ckpt;

    assign w_ptr_inc = r_ptr + PW'(1);
    assign w_ptr_dec = r_ptr - PW'(1);
    assign w_full    = (r_count == DEPTH_CNT);
    assign w_empty   = (r_count == '0);

    // Checkpoint ptr bits above PW belong to larger configurations and are dropped.
    assign w_rc_ptr      = recover_ckpt.ptr[PW-1:0];
    assign w_rc_count    = (recover_ckpt.count > RAS_CKPT_CW'(DEPTH)) ? DEPTH_CNT
                                                                       : recover_ckpt.count[PW:0];
    assign w_unused_ckpt = ^recover_ckpt.ptr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_ovf <= 1'b0;
            if (recover) begin
                r_ptr           <= w_rc_ptr;
                r_count         <= w_rc_count;
                r_mem[w_rc_ptr] <= recover_ckpt.data;
            end else if (push && pop) begin
                // Return immediately followed by a call: replace TOS in place.
                r_mem[r_ptr] <= push_addr;
                if (w_empty) begin
                    r_count <= (PW+1)'(1);
                end
            end else if (push) begin
                r_ptr            <= w_ptr_inc;
                r_mem[w_ptr_inc] <= push_addr;
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + (PW+1)'(1);
                end
            end else if (pop && !w_empty) begin
                r_ptr   <= w_ptr_dec;
                r_count <= r_count - (PW+1)'(1);
            end
        end
    end

    always_comb begin
        top.valid  = !w_empty;
        top.data   = r_mem[r_ptr];
        snap.ptr   = RAS_CKPT_PW'(r_ptr);
        snap.count = RAS_CKPT_CW'(r_count);
        snap.data  = r_mem[r_ptr];
    end

    assign ovf = r_ovf;

endmodule

// File: tb/tb_bpu_ras_param.sv
// Directed bench for the return-address stack at DEPTH = 4 with hand-computed expectations.
module tb_bpu_ras_param;
    import bpu_ras_param_pkg::*;

    logic      clk;
    logic      resetn;
    logic      push;
    virt_t     push_addr;
    logic      pop;
    ras_t      top;
    ras_ckpt_t snap;
    logic      recover;
    ras_ckpt_t recover_ckpt;
    logic      ovf;

    int n_pass;
    int n_fail;
    int n_total;

    bpu_ras_param #(.DEPTH(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .push         (push),
        .push_addr    (push_addr),
        .pop          (pop),
        .top          (top),
        .snap         (snap),
        .recover      (recover),
        .recover_ckpt (recover_ckpt),
        .ovf          (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ras_t mk_top(input logic v, input logic [31:0] d);
        ras_t t;
        t.valid = v;
        t.data  = d;
        return t;
    endfunction

    function automatic ras_ckpt_t mk_ck(input int p, input int c, input logic [31:0] d);
        ras_ckpt_t k;
        k.ptr   = RAS_CKPT_PW'(p);
        k.count = RAS_CKPT_CW'(c);
        k.data  = d;
        return k;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic p, input logic [31:0] a, input logic q);
        push      = p;
        push_addr = a;
        pop       = q;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic rec(input ras_ckpt_t ck, input logic p, input logic q);
        recover      = 1'b1;
        recover_ckpt = ck;
        push         = p;
        push_addr    = 32'hDEAD_0000;
        pop          = q;
        @(posedge clk);
        #1;
        recover = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        resetn = 1'b0; push = 1'b0; push_addr = '0; pop = 1'b0;
        recover = 1'b0; recover_ckpt = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_top",  64'(top),  64'(mk_top(1'b0, 32'h0)));
        chk("reset_snap", 64'(snap), 64'(mk_ck(0, 0, 32'h0)));
        chk("reset_ovf",  64'(ovf),  64'(1'b0));
        resetn = 1'b1;

        // Basic push/pop
        cyc(1'b1, 32'h100, 1'b0);
        cyc(1'b1, 32'h200, 1'b0);
        chk("push2_top",  64'(top),  64'(mk_top(1'b1, 32'h200)));
        chk("push2_snap", 64'(snap), 64'(mk_ck(2, 2, 32'h200)));
        cyc(1'b0, 32'h0, 1'b1);
        chk("pop1_top",   64'(top),  64'(mk_top(1'b1, 32'h100)));
        cyc(1'b0, 32'h0, 1'b1);
        chk("pop_empty_snap", 64'(snap), 64'(mk_ck(0, 0, 32'h0)));

        // Overflow wrap from ptr 0, count 0
        cyc(1'b1, 32'h10, 1'b0);
        cyc(1'b1, 32'h20, 1'b0);
        cyc(1'b1, 32'h30, 1'b0);
        cyc(1'b1, 32'h40, 1'b0);
        chk("full_no_ovf", 64'(ovf),  64'(1'b0));
        chk("full_snap",   64'(snap), 64'(mk_ck(0, 4, 32'h40)));
        cyc(1'b1, 32'h50, 1'b0);
        chk("wrap_ovf",    64'(ovf),  64'(1'b1));
        chk("wrap_snap",   64'(snap), 64'(mk_ck(1, 4, 32'h50)));
        cyc(1'b0, 32'h0, 1'b1);
        chk("ovf_one_cycle", 64'(ovf), 64'(1'b0));
        chk("wpop1_top", 64'(top), 64'(mk_top(1'b1, 32'h40)));
        cyc(1'b0, 32'h0, 1'b1);
        chk("wpop2_top", 64'(top), 64'(mk_top(1'b1, 32'h30)));
        cyc(1'b0, 32'h0, 1'b1);
        chk("wpop3_top", 64'(top), 64'(mk_top(1'b1, 32'h20)));
        cyc(1'b0, 32'h0, 1'b1);
        chk("wpop4_valid", 64'(top.valid), 64'(1'b0));
        chk("wpop4_snap",  64'(snap), 64'(mk_ck(1, 0, 32'h50)));
        cyc(1'b0, 32'h0, 1'b1);
        chk("pop_at_empty_snap", 64'(snap), 64'(mk_ck(1, 0, 32'h50)));

        // Push+pop at count 0
        cyc(1'b1, 32'hA0, 1'b1);
        chk("pushpop_top",  64'(top),  64'(mk_top(1'b1, 32'hA0)));
        chk("pushpop_snap", 64'(snap), 64'(mk_ck(1, 1, 32'hA0)));

        // Build {ptr 1, count 2, 0x200}, diverge, then recover with push asserted
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b1, 32'h100, 1'b1);
        cyc(1'b1, 32'h200, 1'b0);
        chk("ckpt_snap", 64'(snap), 64'(mk_ck(1, 2, 32'h200)));
        cyc(1'b1, 32'h300, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("diverged_top", 64'(top), 64'(mk_top(1'b1, 32'h100)));
        rec(mk_ck(1, 2, 32'h200), 1'b1, 1'b0);
        chk("recover_top",  64'(top),  64'(mk_top(1'b1, 32'h200)));
        chk("recover_snap", 64'(snap), 64'(mk_ck(1, 2, 32'h200)));
        cyc(1'b0, 32'h0, 1'b1);
        chk("recover_below", 64'(top), 64'(mk_top(1'b1, 32'h100)));

        // Count clamp and ignored upper ptr bits; pop ignored during recover
        rec(mk_ck(6'h3E, 9, 32'hBEEF), 1'b0, 1'b1);
        chk("clamp_snap", 64'(snap), 64'(mk_ck(2, 4, 32'hBEEF)));
        cyc(1'b1, 32'h60, 1'b0);
        chk("clamp_full_ovf", 64'(ovf), 64'(1'b1));
        rec(mk_ck(3, 0, 32'h77), 1'b1, 1'b0);
        chk("rec_empty_top", 64'(top), 64'(mk_top(1'b0, 32'h77)));
        chk("rec_no_ovf",    64'(ovf), 64'(1'b0));

        // Reset mid-operation at count 3
        cyc(1'b1, 32'h1, 1'b0);
        cyc(1'b1, 32'h2, 1'b0);
        cyc(1'b1, 32'h3, 1'b0);
        chk("pre_reset_snap", 64'(snap), 64'(mk_ck(2, 3, 32'h3)));
        resetn = 1'b0;
        cyc(1'b1, 32'h4, 1'b0);
        resetn = 1'b1;
        chk("mid_reset_top",  64'(top),  64'(mk_top(1'b0, 32'h0)));
        chk("mid_reset_snap", 64'(snap), 64'(mk_ck(0, 0, 32'h0)));
        chk("mid_reset_ovf",  64'(ovf),  64'(1'b0));
        cyc(1'b1, 32'h9, 1'b0);
        chk("post_reset_push", 64'(snap), 64'(mk_ck(1, 1, 32'h9)));
        cyc(1'b0, 32'h0, 1'b1);
        chk("mem_cleared", 64'(top), 64'(mk_top(1'b0, 32'h0)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
